// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared constants, state encoding and select mapping for the counter readout path
package scope_pkg;

    localparam int         N_CH_DEFAULT   = 16;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_SEL  = 3'd2,
        ST_SEND = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    // The multiplexer is wired in reverse: select 15 returns channel 0.
    function automatic logic [3:0] ch_to_sel(input logic [3:0] idx);
        return 4'd15 - idx;
    endfunction

endpackage

// File: rtl/counter_frame_reader.sv
// rtl/counter_frame_reader.sv - reads 16 multiplexed counters and streams a header/counts/checksum frame
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle frame request, honoured only when idle
//   mux_sel, counter_mux  channel select out, selected 8-bit count in (combinational)
//   tx_data, tx_valid,    byte stream to the host-link transmitter (valid/ready)
//   tx_ready
//   busy, done            frame in progress, one-cycle pulse after the checksum is accepted
module counter_frame_reader
    import scope_pkg::*;
#(
    parameter int         N_CH   = N_CH_DEFAULT,
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] mux_sel,
    input  logic [7:0] counter_mux,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_IDX = 4'(N_CH - 1);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] csum_q, csum_d;
    logic [3:0] sel_d;
    logic [7:0] data_d;
    logic       valid_d, busy_d, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= 4'd0;
            csum_q   <= 8'h00;
            mux_sel  <= 4'd15;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            mux_sel  <= sel_d;
            tx_data  <= data_d;
            tx_valid <= valid_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        sel_d   = mux_sel;
        data_d  = tx_data;
        valid_d = tx_valid;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HDR;
                    data_d  = HEADER;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    idx_d   = 4'd0;
                    csum_d  = 8'h00;
                end
            end
            ST_HDR: begin
                if (tx_ready) begin
                    valid_d = 1'b0;
                    sel_d   = ch_to_sel(idx_q);
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                // The select was changed one cycle ago, so the mux output has settled.
                data_d  = counter_mux;
                valid_d = 1'b1;
                csum_d  = csum_q + counter_mux;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 4'd1;
                        sel_d   = ch_to_sel(idx_q + 4'd1);
                        valid_d = 1'b0;
                        state_d = ST_SEL;
                    end else begin
                        // csum_q already includes the last channel, added in its SEL cycle.
                        data_d  = csum_q;
                        valid_d = 1'b1;
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (tx_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sel_d   = 4'd15;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_counter_frame_reader.sv
// tb/tb_counter_frame_reader.sv - self-checking bench for counter_frame_reader
module tb_counter_frame_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       tx_ready = 1'b1;
    logic [3:0] mux_sel;
    logic [7:0] counter_mux;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       done;

    logic [7:0] ch_val [16];

    // Multiplexer model: select 15 returns channel 0, select 0 returns channel 15.
    assign counter_mux = ch_val[4'd15 - mux_sel];

    counter_frame_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mux_sel     (mux_sel),
        .counter_mux (counter_mux),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: the expected frame as a byte queue, consumed on every handshake.
    logic [7:0] exp_q [$];
    logic [7:0] rx [18];
    int         pos = 0;
    int         frames_done = 0;
    int         done_pulses = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    logic       done_due = 1'b0;
    logic       gap_due = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [3:0] prev_sel = 4'd0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            done_due   = 1'b0;
            gap_due    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("done_pulse", 32'(done), 32'(done_due));
            if (done) done_pulses++;
            done_due = 1'b0;
            if (gap_due) chk("gap_valid_low", 32'(tx_valid), 32'd0);
            gap_due = 1'b0;
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(prev_data));
                chk("hold_sel", 32'(mux_sel), 32'(prev_sel));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got %0h expected no byte", tx_data);
                end else begin
                    chk($sformatf("byte%0d", pos), 32'(tx_data), 32'(exp_q.pop_front()));
                    if (pos >= 1 && pos <= 16)
                        chk($sformatf("sel_byte%0d", pos), 32'(mux_sel), 32'(15 - (pos - 1)));
                    rx[pos] = tx_data;
                    gap_due = (pos <= 15);
                    pos++;
                    if (pos == 18) begin
                        done_due = 1'b1;
                        pos = 0;
                        frames_done++;
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_sel   = mux_sel;
        end
    end

    task automatic push_frame();
        logic [7:0] sum = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(ch_val[k]);
            sum = sum + ch_val[k];
        end
        exp_q.push_back(sum);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    initial begin
        int  n;
        int  fd0, dp0;
        logic hit;
        logic [7:0] s;

        for (int i = 0; i < 16; i++) ch_val[i] = 8'(i + 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mux_sel", 32'(mux_sel), 32'd15);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp counts with a ready transmitter.
        push_frame();
        pulse_start();
        chk("t1_first_valid", 32'(tx_valid), 32'd1);
        chk("t1_first_data", 32'(tx_data), 32'hA5);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done(60);
        chk("t1_done_latency", 32'(cyc - start_cyc), 32'd35);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_sel_end", 32'(mux_sel), 32'd15);
        @(posedge clk); #1;
        chk("t1_done_once", 32'(done), 32'd0);
        chk("t1_rx0", 32'(rx[0]), 32'hA5);
        chk("t1_rx1", 32'(rx[1]), 32'h01);
        chk("t1_rx16", 32'(rx[16]), 32'h10);
        chk("t1_csum", 32'(rx[17]), 32'h88);

        // All counts saturated.
        for (int i = 0; i < 16; i++) ch_val[i] = 8'hFF;
        push_frame();
        pulse_start();
        wait_done(60);
        @(posedge clk); #1;
        chk("t2_rx5", 32'(rx[5]), 32'hFF);
        chk("t2_csum", 32'(rx[17]), 32'hF0);

        // Back-pressure while channel 3 is presented.
        for (int i = 0; i < 16; i++) ch_val[i] = 8'(8'h20 + 3 * i);
        push_frame();
        pulse_start();
        n = 0;
        hit = 1'b0;
        while (!done && n < 100) begin
            if (!hit && tx_valid && mux_sel == 4'd12) begin
                hit = 1'b1;
                tx_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk); #1;
                    chk("t3_stall_sel", 32'(mux_sel), 32'd12);
                    chk("t3_stall_valid", 32'(tx_valid), 32'd1);
                    chk("t3_stall_data", 32'(tx_data), 32'h29);
                end
                tx_ready = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("t3_stall_hit", 32'(hit), 32'd1);
        chk("t3_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("t3_rx4", 32'(rx[4]), 32'h29);

        // Start pulses while busy are dropped.
        fd0 = frames_done;
        dp0 = done_pulses;
        push_frame();
        pulse_start();
        n = 0;
        while (!done && n < 100) begin
            start = (n == 5 || n == 20);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("t4_frames", 32'(frames_done - fd0), 32'd1);
        chk("t4_done_pulses", 32'(done_pulses - dp0), 32'd1);
        chk("t4_idle_valid", 32'(tx_valid), 32'd0);
        chk("t4_idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of channel 7.
        for (int i = 0; i < 16; i++) ch_val[i] = 8'(8'h40 + i);
        push_frame();
        pulse_start();
        n = 0;
        while (!(tx_valid && mux_sel == 4'd8) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_reached_ch7", 32'(mux_sel), 32'd8);
        rst_n = 1'b0;
        #2;
        chk("t5_rst_valid", 32'(tx_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_sel", 32'(mux_sel), 32'd15);
        chk("t5_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        pos = 0;
        fd0 = frames_done;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push_frame();
        pulse_start();
        wait_done(60);
        @(posedge clk); #1;
        chk("t5_frames", 32'(frames_done - fd0), 32'd1);
        chk("t5_rx0", 32'(rx[0]), 32'hA5);
        chk("t5_csum", 32'(rx[17]), 32'h78);

        // Channel 5 changes after it has been sampled.
        for (int i = 0; i < 16; i++) ch_val[i] = 8'(8'h30 + i);
        push_frame();
        pulse_start();
        n = 0;
        hit = 1'b0;
        while (!done && n < 100) begin
            if (!hit && tx_valid && mux_sel == 4'd10) begin
                hit = 1'b1;
                ch_val[5] = 8'hEE;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("t6_change_hit", 32'(hit), 32'd1);
        @(posedge clk); #1;
        chk("t6_old_value", 32'(rx[6]), 32'h35);
        chk("t6_csum", 32'(rx[17]), 32'h78);
        s = 8'h00;
        for (int k = 1; k <= 16; k++) s = s + rx[k];
        chk("t6_csum_consistent", 32'(rx[17]), 32'(s));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
